// File: rtl/stim_pulse_gen.sv
// Purpose : confirm a seizure decision over CONFIRM_N valid samples, then drive a charge-balanced
//           biphasic pulse train followed by a refractory lockout; en=1 aborts with charge balancing.
// Latency : outputs are registered; CATH starts on the edge that samples the confirming strobe.
// Backpr. : none; decisions arriving outside IDLE/CONFIRM are dropped, never queued.
module stim_pulse_gen #(
    parameter int CONFIRM_N   = 2,
    parameter int PHASE_CYC   = 100,
    parameter int GAP_CYC     = 20,
    parameter int PERIOD_CYC  = 1000,
    parameter int PULSES      = 10,
    parameter int REFRACT_CYC = 50000,
    parameter int CNT_W       = 16,
    parameter int EVT_W       = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          sample_valid,
    input  logic                          stim_req,
    output logic                          stim_cath,
    output logic                          stim_anod,
    output logic                          busy,
    output logic                          train_done,
    output logic [$clog2(PULSES+1)-1:0]   pulse_idx,
    output logic [EVT_W-1:0]              train_count
);

    localparam int PI_W     = $clog2(PULSES + 1);
    localparam int CONF_W   = $clog2(CONFIRM_N + 1);
    localparam int REST_CYC = PERIOD_CYC - 2 * PHASE_CYC - GAP_CYC;
    localparam int MAX_DUR  = (PERIOD_CYC > REFRACT_CYC) ? PERIOD_CYC : REFRACT_CYC;

    // Timer reload values: each state lasts (reload + 1) cycles.
    localparam logic [CNT_W-1:0] T_PHASE = CNT_W'(PHASE_CYC - 1);
    localparam logic [CNT_W-1:0] T_GAP   = CNT_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
    localparam logic [CNT_W-1:0] T_REST  = CNT_W'((REST_CYC > 0) ? (REST_CYC - 1) : 0);
    localparam logic [CNT_W-1:0] T_REFR  = CNT_W'(REFRACT_CYC - 1);

    localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONFIRM_N - 1);
    localparam logic [PI_W-1:0]   IDX_LAST  = PI_W'(PULSES - 1);
    localparam logic [EVT_W-1:0]  EVT_SAT   = {EVT_W{1'b1}};

    // Elaboration-time parameter sanity checks.
    if (CONFIRM_N < 1 || PHASE_CYC < 1 || PULSES < 1 || REFRACT_CYC < 1 || GAP_CYC < 0) begin : g_bad_min
        $error("stim_pulse_gen: CONFIRM_N, PHASE_CYC, PULSES, REFRACT_CYC must be >= 1, GAP_CYC >= 0");
    end
    if (PERIOD_CYC < 2 * PHASE_CYC + GAP_CYC + 1) begin : g_bad_period
        $error("stim_pulse_gen: PERIOD_CYC must be >= 2*PHASE_CYC+GAP_CYC+1");
    end
    if (longint'(MAX_DUR) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_cnt_w
        $error("stim_pulse_gen: CNT_W too narrow for max(PERIOD_CYC, REFRACT_CYC)");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIRM,
        S_CATH,
        S_GAP,
        S_ANOD,
        S_REST,
        S_REFRACT,
        S_ABORT
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    timer;
    logic [CNT_W-1:0]    cath_elapsed;   // CATH cycles spent in the current pulse, for abort balancing
    logic [CONF_W-1:0]   conf_cnt;
    logic                abort_pend;     // abort seen during ANOD; finish the phase then go idle

    // Output decode for a state: {stim_cath, stim_anod, busy}. Applied to the next state so the
    // outputs are registered alongside it.
    function automatic logic [2:0] drv(input state_t s);
        logic [2:0] r;
        r = 3'b000;
        case (s)
            S_CATH:    r = 3'b101;
            S_GAP:     r = 3'b001;
            S_ANOD:    r = 3'b011;
            S_REST:    r = 3'b001;
            S_REFRACT: r = 3'b001;
            S_ABORT:   r = 3'b011;
            default:   r = 3'b000;
        endcase
        return r;
    endfunction

    // Main control FSM: confirmation, pulse sequencing, lockout, abort with charge balancing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                          <= S_IDLE;
            timer                          <= '0;
            cath_elapsed                   <= '0;
            conf_cnt                       <= '0;
            abort_pend                     <= 1'b0;
            {stim_cath, stim_anod, busy}   <= 3'b000;
            train_done                     <= 1'b0;
            pulse_idx                      <= '0;
            train_count                    <= '0;
        end else begin
            train_done <= 1'b0;
            case (state)
                S_IDLE, S_CONFIRM: begin
                    if (en) begin
                        state    <= S_IDLE;
                        conf_cnt <= '0;
                    end else if (sample_valid) begin
                        if (!stim_req) begin
                            state    <= S_IDLE;
                            conf_cnt <= '0;
                        end else if (conf_cnt == CONF_LAST) begin
                            state                        <= S_CATH;
                            timer                        <= T_PHASE;
                            cath_elapsed                 <= CNT_W'(1);
                            conf_cnt                     <= '0;
                            pulse_idx                    <= '0;
                            {stim_cath, stim_anod, busy} <= drv(S_CATH);
                            if (train_count != EVT_SAT) begin
                                train_count <= train_count + EVT_W'(1);
                            end
                        end else begin
                            state    <= S_CONFIRM;
                            conf_cnt <= conf_cnt + CONF_W'(1);
                        end
                    end
                end

                S_CATH: begin
                    if (en) begin
                        // Balance exactly the cathodic charge already delivered.
                        state                        <= S_ABORT;
                        timer                        <= cath_elapsed - CNT_W'(1);
                        {stim_cath, stim_anod, busy} <= drv(S_ABORT);
                    end else if (timer == '0) begin
                        if (GAP_CYC > 0) begin
                            state                        <= S_GAP;
                            timer                        <= T_GAP;
                            {stim_cath, stim_anod, busy} <= drv(S_GAP);
                        end else begin
                            state                        <= S_ANOD;
                            timer                        <= T_PHASE;
                            {stim_cath, stim_anod, busy} <= drv(S_ANOD);
                        end
                    end else begin
                        timer        <= timer - CNT_W'(1);
                        cath_elapsed <= cath_elapsed + CNT_W'(1);
                    end
                end

                S_GAP: begin
                    if (en) begin
                        state                        <= S_ABORT;
                        timer                        <= cath_elapsed - CNT_W'(1);
                        {stim_cath, stim_anod, busy} <= drv(S_ABORT);
                    end else if (timer == '0) begin
                        state                        <= S_ANOD;
                        timer                        <= T_PHASE;
                        {stim_cath, stim_anod, busy} <= drv(S_ANOD);
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end

                S_ANOD: begin
                    if (en) begin
                        abort_pend <= 1'b1;
                    end
                    if (timer == '0) begin
                        if (en || abort_pend) begin
                            state                        <= S_IDLE;
                            timer                        <= '0;
                            conf_cnt                     <= '0;
                            pulse_idx                    <= '0;
                            abort_pend                   <= 1'b0;
                            {stim_cath, stim_anod, busy} <= drv(S_IDLE);
                        end else begin
                            state                        <= S_REST;
                            timer                        <= T_REST;
                            {stim_cath, stim_anod, busy} <= drv(S_REST);
                        end
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end

                S_REST: begin
                    if (en) begin
                        state                        <= S_IDLE;
                        timer                        <= '0;
                        conf_cnt                     <= '0;
                        pulse_idx                    <= '0;
                        {stim_cath, stim_anod, busy} <= drv(S_IDLE);
                    end else if (timer == '0) begin
                        if (pulse_idx < IDX_LAST) begin
                            state                        <= S_CATH;
                            timer                        <= T_PHASE;
                            cath_elapsed                 <= CNT_W'(1);
                            pulse_idx                    <= pulse_idx + PI_W'(1);
                            {stim_cath, stim_anod, busy} <= drv(S_CATH);
                        end else begin
                            state                        <= S_REFRACT;
                            timer                        <= T_REFR;
                            train_done                   <= 1'b1;
                            {stim_cath, stim_anod, busy} <= drv(S_REFRACT);
                        end
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end

                S_REFRACT: begin
                    if (en || timer == '0) begin
                        state                        <= S_IDLE;
                        timer                        <= '0;
                        conf_cnt                     <= '0;
                        pulse_idx                    <= '0;
                        {stim_cath, stim_anod, busy} <= drv(S_IDLE);
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end

                S_ABORT: begin
                    // en is ignored here: balancing always runs to completion.
                    if (timer == '0) begin
                        state                        <= S_IDLE;
                        conf_cnt                     <= '0;
                        pulse_idx                    <= '0;
                        abort_pend                   <= 1'b0;
                        {stim_cath, stim_anod, busy} <= drv(S_IDLE);
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end

                default: begin
                    state                        <= S_IDLE;
                    timer                        <= '0;
                    conf_cnt                     <= '0;
                    pulse_idx                    <= '0;
                    abort_pend                   <= 1'b0;
                    {stim_cath, stim_anod, busy} <= 3'b000;
                end
            endcase
        end
    end

endmodule
